// File: rtl/dma_channel_arbiter.sv
// -----------------------------------------------------------------------------
// dma_channel_arbiter
//
// Purpose:
//   Multi-channel DMA front end. Start requests from NUM_CH devices are latched
//   into a pending vector, and one channel is picked at a time by round-robin.
//   The selected channel's command address is presented to the CPU. The bus
//   request/grant handshake runs once neither memory port is busy, and a
//   watchdog bounds the wait for transfer completion. Completion or timeout is
//   reported as a one-cycle per-channel done/error pulse.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   if_memoryWait  in   instruction-side memory busy
//   mem_memoryWait in   data-side memory busy
//   dma_begin      in   [NUM_CH] per-channel start pulse/level
//   dma_command    out  [WORD_SIZE] command address; high-Z when not issuing
//   cmd_channel    out  [CH_W] channel index being issued/served
//   bus_request    in   CPU requests bus release
//   dma_using      out  DMA owns the memory bus (GRANT and WAIT_END)
//   bus_grant      out  grant to the CPU-side handshake (GRANT only)
//   dma_end        in   transfer complete from the DMA engine
//   pending        out  [NUM_CH] latched, not-yet-served requests
//   done           out  [NUM_CH] one-cycle pulse on channel completion
//   error          out  [NUM_CH] one-cycle pulse on channel timeout
// -----------------------------------------------------------------------------
module dma_channel_arbiter #(
   parameter int                   WORD_SIZE = 16,
   parameter int                   NUM_CH    = 4,
   parameter int                   CH_W      = 2,
   parameter logic [WORD_SIZE-1:0] DMA_BASE  = 16'h01f4,
   parameter logic [WORD_SIZE-1:0] CH_STRIDE = 16'h0004,
   parameter int                   TIMEOUT   = 1024
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 if_memoryWait,
   input  logic                 mem_memoryWait,
   input  logic [NUM_CH-1:0]    dma_begin,
   output logic [WORD_SIZE-1:0] dma_command,
   output logic [CH_W-1:0]      cmd_channel,
   input  logic                 bus_request,
   output logic                 dma_using,
   output logic                 bus_grant,
   input  logic                 dma_end,
   output logic [NUM_CH-1:0]    pending,
   output logic [NUM_CH-1:0]    done,
   output logic [NUM_CH-1:0]    error
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_GRANT,
      ST_WAIT_END
   } state_t;

   // Timer is wide enough to hold TIMEOUT; a disabled watchdog still keeps a
   // one-bit counter so the datapath stays well formed.
   localparam int              TMR_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;
   localparam logic [TMR_W-1:0] TMR_MAX  = '1;

   state_t                 state, state_next;
   logic [NUM_CH-1:0]      pending_next;
   logic [CH_W-1:0]        rr_ptr, rr_next;
   logic [CH_W-1:0]        cmd_ch_next;
   logic [TMR_W-1:0]       timer, timer_next;
   logic [NUM_CH-1:0]      done_next, error_next;

   logic                   sel_found;
   logic [CH_W-1:0]        sel_ch;
   logic [NUM_CH-1:0]      sel_onehot;
   logic [NUM_CH-1:0]      cur_onehot;
   logic [CH_W-1:0]        cur_plus_one;
   logic [WORD_SIZE-1:0]   cmd_addr;
   logic                   issue_go;
   logic                   timed_out;

   // ---------------------------------------------------------------------------
   // Round-robin pick: first pending channel at or after rr_ptr, else the first
   // pending channel below rr_ptr (the wrap-around part of the search).
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every combinational output gets a default before any branch so
      // that no path leaves it unassigned and no latch is inferred.
      sel_found = 1'b0;
      sel_ch    = '0;
      for (int j = 0; j < NUM_CH; j++) begin
         if (!sel_found && pending[j] && (CH_W'(j) >= rr_ptr)) begin
            sel_found = 1'b1;
            sel_ch    = CH_W'(j);
         end
      end
      for (int j = 0; j < NUM_CH; j++) begin
         if (!sel_found && pending[j] && (CH_W'(j) < rr_ptr)) begin
            sel_found = 1'b1;
            sel_ch    = CH_W'(j);
         end
      end
   end

   assign sel_onehot   = NUM_CH'(1) << sel_ch;
   assign cur_onehot   = NUM_CH'(1) << cmd_channel;
   assign cur_plus_one = (cmd_channel == CH_W'(NUM_CH - 1)) ? '0 : cmd_channel + 1'b1;

   // Command address wraps naturally at WORD_SIZE bits.
   assign cmd_addr    = DMA_BASE + WORD_SIZE'(cmd_channel) * CH_STRIDE;
   assign dma_command = (state == ST_ISSUE) ? cmd_addr : 'z;

   // Decoded straight from the state register, so an asynchronous reset drops
   // them immediately and grant can never overlap a valid command.
   assign dma_using = (state == ST_GRANT) || (state == ST_WAIT_END);
   assign bus_grant = (state == ST_GRANT);

   assign issue_go  = bus_request && !if_memoryWait && !mem_memoryWait;
   assign timed_out = (TIMEOUT != 0) && (timer == TMR_LAST);

   // ---------------------------------------------------------------------------
   // Next-state and datapath decisions.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next   = state;
      pending_next = pending | dma_begin;
      cmd_ch_next  = cmd_channel;
      rr_next      = rr_ptr;
      timer_next   = timer;
      done_next    = '0;
      error_next   = '0;

      case (state)
         ST_IDLE: begin
            if (sel_found) begin
               state_next   = ST_ISSUE;
               cmd_ch_next  = sel_ch;
               // A same-cycle new request on the picked channel re-arms it.
               pending_next = (pending & ~sel_onehot) | dma_begin;
            end
         end

         ST_ISSUE: begin
            if (issue_go) begin
               state_next = ST_GRANT;
            end
         end

         ST_GRANT: begin
            if (!bus_request) begin
               state_next = ST_WAIT_END;
               timer_next = '0;
            end
         end

         ST_WAIT_END: begin
            if (timer != TMR_MAX) begin
               timer_next = timer + 1'b1;
            end
            // Completion has priority over a coincident timeout.
            if (dma_end) begin
               state_next = ST_IDLE;
               done_next  = cur_onehot;
               rr_next    = cur_plus_one;
            end else if (timed_out) begin
               state_next = ST_IDLE;
               error_next = cur_onehot;
               rr_next    = cur_plus_one;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State register and registered datapath.
   // ---------------------------------------------------------------------------
   // NOTE: reset is asynchronous so the bus is released even without a clock;
   // every flop here is a control register, so all of them are reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         pending     <= '0;
         rr_ptr      <= '0;
         cmd_channel <= '0;
         timer       <= '0;
         done        <= '0;
         error       <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge
         // values, independent of statement order.
         state       <= state_next;
         pending     <= pending_next;
         rr_ptr      <= rr_next;
         cmd_channel <= cmd_ch_next;
         timer       <= timer_next;
         done        <= done_next;
         error       <= error_next;
      end
   end

endmodule
